// File: rtl/tile_sprite_streamer.sv
// Tile sprite row streamer: holds rule-generated tile bitmaps and streams one
// requested row per request, one pixel per beat, with optional mirror/2x scale.
module tile_sprite_streamer #(
    parameter int TILE_W    = 32,
    parameter int TILE_H    = 16,
    parameter int N_TILES   = 4,
    parameter int TILE_BITS = (N_TILES > 1) ? $clog2(N_TILES) : 1,
    parameter int ROW_BITS  = (TILE_H > 1) ? $clog2(TILE_H) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [TILE_BITS-1:0] req_tile,
    input  logic [ROW_BITS-1:0]  req_row,
    input  logic                 req_mirror,
    input  logic                 req_scale2,
    output logic                 px_valid,
    input  logic                 px_ready,
    output logic                 px_out,
    output logic                 px_last,
    output logic                 busy
);

    localparam int IW = $clog2(TILE_W);
    localparam int CW = $clog2(2 * TILE_W) + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    localparam logic [IW-1:0] LAST_COL     = IW'(TILE_W - 1);
    localparam logic [CW-1:0] LAST_BEAT_1X = CW'(TILE_W - 1);
    localparam logic [CW-1:0] LAST_BEAT_2X = CW'(2 * TILE_W - 1);

    logic [1:0]           state_q,  state_d;
    logic [TILE_BITS-1:0] tile_q,   tile_d;
    logic [ROW_BITS-1:0]  row_q,    row_d;
    logic                 mirror_q, mirror_d;
    logic                 scale2_q, scale2_d;
    logic [TILE_W-1:0]    line_q,   line_d;
    logic [CW-1:0]        beat_q,   beat_d;

    logic [TILE_W-1:0]    line_rule;
    int unsigned          tile_i;
    int unsigned          row_i;
    logic [IW-1:0]        pix_idx;
    logic [IW-1:0]        bit_idx;
    logic                 at_last;

    // Sprite ROM: line for the captured tile/row, column 0 in the MSB
    always_comb begin
        line_rule = '0;
        tile_i    = 32'(tile_q);
        row_i     = 32'(row_q);
        if (row_i < TILE_H) begin
            for (int unsigned c = 0; c < TILE_W; c++) begin
                case (tile_i)
                    0:       line_rule[TILE_W-1-c] = 1'b1;
                    2:       line_rule[TILE_W-1-c] = (c == row_i) || (c == TILE_W - 1 - row_i);
                    3:       line_rule[TILE_W-1-c] = (c == 0) || (c == TILE_W - 1) ||
                                                     (row_i == 0) || (row_i == TILE_H - 1);
                    default: line_rule[TILE_W-1-c] = 1'b0;
                endcase
            end
        end
    end

    // Beat to line-bit mapping; mirrored column TILE_W-1-p lands on bit p
    always_comb begin
        pix_idx = scale2_q ? beat_q[IW:1] : beat_q[IW-1:0];
        bit_idx = mirror_q ? pix_idx : LAST_COL - pix_idx;
        at_last = (beat_q == (scale2_q ? LAST_BEAT_2X : LAST_BEAT_1X));
    end

    // Outputs decoded purely from registered state, so they hold during stalls
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        px_valid  = (state_q == ST_STREAM);
        px_out    = px_valid & line_q[bit_idx];
        px_last   = px_valid & at_last;
    end

    // FSM next state: capture request, load line, then stream beats
    always_comb begin
        state_d  = state_q;
        tile_d   = tile_q;
        row_d    = row_q;
        mirror_d = mirror_q;
        scale2_d = scale2_q;
        line_d   = line_q;
        beat_d   = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    tile_d   = req_tile;
                    row_d    = req_row;
                    mirror_d = req_mirror;
                    scale2_d = req_scale2;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                line_d  = line_rule;
                beat_d  = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (px_ready) begin
                    if (at_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset discarding any partial row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tile_q   <= '0;
            row_q    <= '0;
            mirror_q <= 1'b0;
            scale2_q <= 1'b0;
            line_q   <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            tile_q   <= tile_d;
            row_q    <= row_d;
            mirror_q <= mirror_d;
            scale2_q <= scale2_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
        end
    end

endmodule

// File: tb/tb_tile_sprite_streamer.sv
// Directed bench for tile_sprite_streamer: default instance plus an N_TILES=6
// instance sharing the same stimulus; a select picks which one is observed.
module tb_tile_sprite_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [2:0] req_tile;
    logic [3:0] req_row;
    logic       req_mirror;
    logic       req_scale2;
    logic       px_ready;
    logic       sel6;

    logic req_ready4, px_valid4, px_out4, px_last4, busy4;
    logic req_ready6, px_valid6, px_out6, px_last6, busy6;
    logic o_req_ready, o_px_valid, o_px_out, o_px_last, o_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tile_sprite_streamer dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready4),
        .req_tile(req_tile[1:0]), .req_row(req_row),
        .req_mirror(req_mirror), .req_scale2(req_scale2),
        .px_valid(px_valid4), .px_ready(px_ready),
        .px_out(px_out4), .px_last(px_last4), .busy(busy4)
    );

    tile_sprite_streamer #(.N_TILES(6)) dut6 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready6),
        .req_tile(req_tile), .req_row(req_row),
        .req_mirror(req_mirror), .req_scale2(req_scale2),
        .px_valid(px_valid6), .px_ready(px_ready),
        .px_out(px_out6), .px_last(px_last6), .busy(busy6)
    );

    assign o_req_ready = sel6 ? req_ready6 : req_ready4;
    assign o_px_valid  = sel6 ? px_valid6  : px_valid4;
    assign o_px_out    = sel6 ? px_out6    : px_out4;
    assign o_px_last   = sel6 ? px_last6   : px_last4;
    assign o_busy      = sel6 ? busy6      : busy4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a request at a negedge and verify the one-cycle FETCH gap.
    task automatic request(input logic [2:0] tile, input logic [3:0] row,
                           input logic mirror, input logic scale2);
        req_tile   = tile;
        req_row    = row;
        req_mirror = mirror;
        req_scale2 = scale2;
        req_valid  = 1'b1;
        check("req_ready_idle", o_req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("fetch_px_valid", o_px_valid, 0);
        check("fetch_req_ready", o_req_ready, 0);
        check("fetch_busy", o_busy, 1);
        @(negedge clk);
        check("first_px_valid", o_px_valid, 1);
    endtask

    // Consume a row; mask bit i is the expected pixel of beat i.
    task automatic stream(input string tag, input logic [63:0] mask, input int n,
                          input bit stall, input bit scramble);
        int   idx = 0;
        int   cyc = 0;
        logic held = 1'b0;
        logic held_out = 1'b0;
        logic held_last = 1'b0;
        while (idx < n && cyc < 600) begin
            if (held) begin
                check($sformatf("%s_hold_out_b%0d", tag, idx), o_px_out, held_out);
                check($sformatf("%s_hold_last_b%0d", tag, idx), o_px_last, held_last);
            end
            px_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (scramble) begin
                req_tile   = 3'($urandom_range(0, 7));
                req_row    = 4'($urandom_range(0, 15));
                req_mirror = 1'($urandom_range(0, 1));
                req_scale2 = 1'($urandom_range(0, 1));
            end
            check($sformatf("%s_valid_b%0d", tag, idx), o_px_valid, 1);
            if (px_ready) begin
                check($sformatf("%s_out_b%0d", tag, idx), o_px_out, mask[idx]);
                check($sformatf("%s_last_b%0d", tag, idx), o_px_last, (idx == n - 1) ? 1 : 0);
                idx++;
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_out  = o_px_out;
                held_last = o_px_last;
            end
            cyc++;
            @(negedge clk);
        end
        check($sformatf("%s_beat_count", tag), idx, n);
        px_ready = 1'b0;
        check($sformatf("%s_idle_req_ready", tag), o_req_ready, 1);
        check($sformatf("%s_idle_px_valid", tag), o_px_valid, 0);
        check($sformatf("%s_idle_busy", tag), o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m_hit3;
        logic [63:0] m_hit0;
        logic [63:0] m_frame2x;
        logic [63:0] m_frame1x;
        m_hit3    = (64'd1 << 3) | (64'd1 << 28);
        m_hit0    = (64'd1 << 0) | (64'd1 << 31);
        m_frame2x = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 62) | (64'd1 << 63);
        m_frame1x = (64'd1 << 0) | (64'd1 << 31);

        rst = 1'b1; req_valid = 1'b0; req_tile = '0; req_row = '0;
        req_mirror = 1'b0; req_scale2 = 1'b0; px_ready = 1'b0; sel6 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", o_req_ready, 1);
        check("rst_px_valid", o_px_valid, 0);
        check("rst_px_out", o_px_out, 0);
        check("rst_px_last", o_px_last, 0);
        check("rst_busy", o_busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // ship row, plain
        request(3'd0, 4'd5, 1'b0, 1'b0);
        stream("ship", 64'h0000_0000_FFFF_FFFF, 32, 1'b0, 1'b0);

        // hit diagonal, both orientations, then the corner row mirrored
        request(3'd2, 4'd3, 1'b0, 1'b0);
        stream("hit_r3", m_hit3, 32, 1'b0, 1'b0);
        request(3'd2, 4'd3, 1'b1, 1'b0);
        stream("hit_r3_mir", m_hit3, 32, 1'b0, 1'b0);
        request(3'd2, 4'd0, 1'b1, 1'b0);
        stream("hit_r0_mir", m_hit0, 32, 1'b0, 1'b0);

        // frame side walls at 2x scale
        request(3'd3, 4'd7, 1'b0, 1'b1);
        stream("frame_2x", m_frame2x, 64, 1'b0, 1'b0);

        // frame top edge: full row
        request(3'd3, 4'd0, 1'b0, 1'b0);
        stream("frame_top", 64'h0000_0000_FFFF_FFFF, 32, 1'b0, 1'b0);

        // random back-pressure with inputs churning during the stream
        request(3'd2, 4'd3, 1'b0, 1'b0);
        stream("hit_stall", m_hit3, 32, 1'b1, 1'b1);

        // asynchronous reset mid-row
        request(3'd0, 4'd5, 1'b0, 1'b0);
        px_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("pre_rst_out_b%0d", i), o_px_out, 1);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_px_valid", o_px_valid, 0);
        check("mid_rst_req_ready", o_req_ready, 1);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_px_out", o_px_out, 0);
        check("mid_rst_px_last", o_px_last, 0);
        @(negedge clk);
        rst = 1'b0;
        px_ready = 1'b0;
        @(negedge clk);
        request(3'd1, 4'd2, 1'b0, 1'b0);
        stream("empty_after_rst", 64'd0, 32, 1'b0, 1'b0);

        // six-tile instance: tile 3 is still the frame, tile 5 is blank
        sel6 = 1'b1;
        request(3'd3, 4'd7, 1'b0, 1'b0);
        stream("n6_frame", m_frame1x, 32, 1'b0, 1'b0);
        request(3'd5, 4'd3, 1'b0, 1'b0);
        stream("n6_tile5", 64'd0, 32, 1'b0, 1'b1);
        sel6 = 1'b0;

        // captured row frozen while req_row changes under a stream
        request(3'd2, 4'd0, 1'b0, 1'b0);
        stream("row_frozen", m_hit0, 32, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
